sseg_scan_mux: RTL and testbench
================================

// Module: sseg_scan_mux
// PURPOSE
//   Time-multiplexed 4-digit seven-segment scan driver. Consumes four active-low 8-bit
//   segment patterns (in0..in3) from pattern generators such as the rotating-square
//   block and drives shared active-low anodes/segments.
//   Inputs are frame-latched (no tearing); a guard blank at each slot start suppresses ghosting.
// PARAMETERS
//   REFRESH_POWER  18  scan counter width N; frame = 2**N clks, slot = 2**(N-2) clks; N>=3
//   GUARD_CYCLES   16  blank clks at start of each slot; 0..2**(N-2); 0 = no guard
// PORTS
//   clk         in   1  clock, all logic on rising edge
//   reset       in   1  synchronous, active-high
//   in0..in3    in   8  segment patterns, active-low (8'hFF = blank), digit 0..3
//   digit_en    in   4  per-digit enable, bit k enables digit k, sampled live
//   an          out  4  anode drive, active-low, registered
//   sseg        out  8  segment drive, active-low, registered
//   frame_tick  out  1  one-clk pulse per frame, registered
//   brightness  in   4  duty level (present only with DISP_MUX_DIM_EN)
// BEHAVIOUR
//   - Reset: scan_reg=0, shadow0..3=8'hFF, an=4'b1111, sseg=8'hFF, frame_tick=0.
//     Reset mid-frame aborts the scan; values above apply at the next edge.
//   - scan_reg: N-bit counter, +1 every clk, wraps 2**N-1 -> 0. No enable, no stall.
//     slot = scan_reg[N-1:N-2]; phase = scan_reg[N-3:0].
//   - Frame latch: on the edge where scan_reg==2**N-1, shadow_k <= in_k (all four together).
//     frame_tick <= (scan_reg==2**N-1). frame_tick is therefore high while scan_reg==0.
//     Its period is exactly 2**N clks.
//   - Output register, 1-clk latency from scan_reg:
//     lit = digit_en[slot] && (phase >= GUARD_CYCLES) [&& dim_ok, see CONFIGURATION]
//     lit:     an <= ~(4'b0001 << slot); sseg <= shadow[slot]
//     not lit: an <= 4'b1111; sseg <= 8'hFF
//   - At most one an bit is low in any cycle. No two digits ever overlap.
//   - New shadow values first reach sseg on the edge after scan_reg==0.
//     in_k changes mid-frame are invisible until the next frame latch.
//   - GUARD_CYCLES==2**(N-2): digits are never lit. This is legal and not an error.
//   - digit_en is not shadowed. A change takes effect 1 clk later, even mid-slot.
// CONFIGURATION
//   DISP_MUX_DIM_EN defined:
//     - brightness port exists. It is shadowed at the frame latch; reset value 4'hF.
//     - dim_ok = (phase[N-3 -: 4] <= bright_shadow), giving duty (b+1)/16 of the non-guard window.
//     - Requires N>=6.
//   DISP_MUX_DIM_EN undefined:
//     - The brightness port and shadow register are absent; dim_ok = 1 (full duty).
// TESTING (REFRESH_POWER=6, GUARD_CYCLES=2: slot = 16 clks, frame = 64 clks)
//   1 reset high 3 clks -> an=4'b1111, sseg=8'hFF, frame_tick=0. After release, first
//     frame_tick arrives 64 clks after the first non-reset edge.
//   2 in0=8'hAC, in1..3=8'hFF, digit_en=4'hF, after 1st frame_tick -> slot0 phases 0-1:
//     an=1111/sseg=FF; phases 2-15: an=1110/sseg=AC; slots1-3 lit with an=1101,1011,0111, sseg=FF.
//   3 in2 8'hFF->8'h9C mid slot 1 -> slot2 shows FF this frame, 9C from next frame. Never a partial frame.
//   4 digit_en=4'b1011 -> entire slot 2: an=1111, sseg=FF; other slots unaffected; check one-hot-low an.
//   5 reset asserted at phase 7 of slot 2 -> next edge all reset values. Scan restarts at slot 0;
//     frame_tick spacing of 64 clks is re-established from release.
//   6 (DIM_EN) brightness=3 -> per slot an low only at phases 2,3. brightness=15 -> phases 2-15.
//     A change mid-frame applies from the next frame.

Source files
------------

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: time-multiplexed 4-digit seven-segment scan driver.
//
// Walks a free-running scan counter over four digit slots and drives the shared
// active-low anodes and segments. The four input patterns are captured together once
// per frame so a digit never shows a half-updated pattern, and the first
// GUARD_CYCLES clocks of every slot are blanked so the previous digit cannot ghost.
//
// Parameters
//   REFRESH_POWER  scan counter width N; frame = 2**N clks, slot = 2**(N-2) clks (N >= 3)
//   GUARD_CYCLES   blanked clks at the start of each slot, 0 .. 2**(N-2)
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   in0..in3    in   [7:0] active-low segment patterns for digits 0..3 (8'hFF = blank)
//   digit_en    in   [3:0] live per-digit enable, bit k enables digit k
//   brightness  in   [3:0] duty level, only when DISP_MUX_DIM_EN is defined
//   an          out  [3:0] active-low anode drive, registered
//   sseg        out  [7:0] active-low segment drive, registered
//   frame_tick  out  one-clk pulse per frame, high while the scan counter is 0
//
// Build option
//   DISP_MUX_DIM_EN  adds the brightness port; duty (b+1)/16 of the unguarded window.
//                    Needs REFRESH_POWER >= 6.

module sseg_scan_mux #(
    parameter int unsigned REFRESH_POWER = 18,
    parameter int unsigned GUARD_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [3:0] digit_en,
`ifdef DISP_MUX_DIM_EN
    input  logic [3:0] brightness,
`endif
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    localparam int unsigned N  = REFRESH_POWER;
    localparam int unsigned PW = REFRESH_POWER - 2;

    logic [N-1:0]  scan_q, scan_d;
    logic [7:0]    shadow0_q, shadow1_q, shadow2_q, shadow3_q;
    logic [3:0]    an_q, an_d;
    logic [7:0]    sseg_q, sseg_d;
    logic          frame_tick_q;

    logic [1:0]    slot;
    logic [PW-1:0] phase;
    logic          frame_end;
    logic          guard_ok;
    logic          dim_ok;
    logic          lit;
    logic [7:0]    slot_pat;
    logic [3:0]    slot_an;

    assign slot      = scan_q[N-1 -: 2];
    assign phase     = scan_q[PW-1:0];
    assign frame_end = (scan_q == {N{1'b1}});
    assign scan_d    = scan_q + {{(N-1){1'b0}}, 1'b1};

    // Compare at 32 bits so GUARD_CYCLES == slot length (never lit) is representable.
    assign guard_ok  = (32'(phase) >= GUARD_CYCLES);

`ifdef DISP_MUX_DIM_EN
    logic [3:0] bright_q;
    // Top four phase bits split the slot into 16 steps; lit for steps 0..brightness.
    assign dim_ok = (phase[PW-1 -: 4] <= bright_q);
`else
    assign dim_ok = 1'b1;
`endif

    assign lit = digit_en[slot] && guard_ok && dim_ok;

    always_comb begin
        slot_pat = 8'hFF;
        slot_an  = 4'b1111;
        unique case (slot)
            2'd0: begin slot_pat = shadow0_q; slot_an = 4'b1110; end
            2'd1: begin slot_pat = shadow1_q; slot_an = 4'b1101; end
            2'd2: begin slot_pat = shadow2_q; slot_an = 4'b1011; end
            2'd3: begin slot_pat = shadow3_q; slot_an = 4'b0111; end
        endcase
    end

    always_comb begin
        an_d   = 4'b1111;
        sseg_d = 8'hFF;
        if (lit) begin
            an_d   = slot_an;
            sseg_d = slot_pat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q       <= '0;
            shadow0_q    <= 8'hFF;
            shadow1_q    <= 8'hFF;
            shadow2_q    <= 8'hFF;
            shadow3_q    <= 8'hFF;
            an_q         <= 4'b1111;
            sseg_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
`ifdef DISP_MUX_DIM_EN
            bright_q     <= 4'hF;
`endif
        end else begin
            scan_q       <= scan_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_tick_q <= frame_end;
            // Capture all four patterns on the same edge so a frame is never torn.
            if (frame_end) begin
                shadow0_q <= in0;
                shadow1_q <= in1;
                shadow2_q <= in2;
                shadow3_q <= in3;
`ifdef DISP_MUX_DIM_EN
                bright_q  <= brightness;
`endif
            end
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Scoreboard bench for sseg_scan_mux with REFRESH_POWER=6, GUARD_CYCLES=2
// (slot = 16 clks, frame = 64 clks). The driver pushes the expected registered
// outputs for every upcoming clock edge; the monitor pops and compares one entry
// per cycle on the falling edge. Define DISP_MUX_DIM_EN to also cover dimming.

module tb_sseg_scan_mux;

    localparam int unsigned N = 6;
    localparam int unsigned G = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] digit_en;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;
`ifdef DISP_MUX_DIM_EN
    logic [3:0] brightness;
`endif

    always #5 clk = ~clk;

    sseg_scan_mux #(
        .REFRESH_POWER (N),
        .GUARD_CYCLES  (G)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .digit_en   (digit_en),
`ifdef DISP_MUX_DIM_EN
        .brightness (brightness),
`endif
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
        logic       ft;
        logic       rst;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: scan position and frame-captured values as seen by the driver.
    int         s_m = 0;
    logic [7:0] sh_m [4];
    logic [3:0] br_m = 4'hF;

    // Expected outputs after the coming edge, given the inputs currently applied.
    task automatic push_exp();
        exp_t e;
        int   slot;
        int   phase;
        logic lit;
        if (reset) begin
            e.an   = 4'b1111;
            e.sseg = 8'hFF;
            e.ft   = 1'b0;
            e.rst  = 1'b1;
            s_m    = 0;
            for (int k = 0; k < 4; k++) sh_m[k] = 8'hFF;
            br_m   = 4'hF;
        end else begin
            slot  = s_m / 16;
            phase = s_m % 16;
            lit   = digit_en[slot] && (phase >= int'(G));
`ifdef DISP_MUX_DIM_EN
            lit   = lit && (phase <= int'(br_m));
`endif
            e.rst = 1'b0;
            e.ft  = (s_m == 63);
            if (lit) begin
                case (slot)
                    0:       e.an = 4'b1110;
                    1:       e.an = 4'b1101;
                    2:       e.an = 4'b1011;
                    default: e.an = 4'b0111;
                endcase
                e.sseg = sh_m[slot];
            end else begin
                e.an   = 4'b1111;
                e.sseg = 8'hFF;
            end
            if (s_m == 63) begin
                sh_m[0] = in0;
                sh_m[1] = in1;
                sh_m[2] = in2;
                sh_m[3] = in3;
`ifdef DISP_MUX_DIM_EN
                br_m    = brightness;
`endif
            end
            s_m = (s_m + 1) % 64;
        end
        q.push_back(e);
    endtask

    task automatic cyc();
        push_exp();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // Monitor: one expected entry per edge, plus one-hot anode and tick spacing checks.
    initial begin : monitor
        exp_t e;
        int   since;
        int   last;
        since = 0;
        last  = -1;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({an, sseg, frame_tick} !== {e.an, e.sseg, e.ft}) begin
                    errors++;
                    $display("FAIL outputs @%0t: got an=%b sseg=%h tick=%b, want an=%b sseg=%h tick=%b",
                             $time, an, sseg, frame_tick, e.an, e.sseg, e.ft);
                end
                checks++;
                if (!$onehot0(~an)) begin
                    errors++;
                    $display("FAIL anode_onehot @%0t: got an=%b, want at most one low bit",
                             $time, an);
                end
                if (e.rst) begin
                    since = 0;
                    last  = -1;
                end else begin
                    since++;
                    if (frame_tick === 1'b1) begin
                        checks++;
                        if (last < 0) begin
                            if (since != 64) begin
                                errors++;
                                $display("FAIL first_tick @%0t: got edge %0d after release, want 64",
                                         $time, since);
                            end
                        end else if (since - last != 64) begin
                            errors++;
                            $display("FAIL tick_period @%0t: got %0d clks, want 64",
                                     $time, since - last);
                        end
                        last = since;
                    end
                end
            end
        end
    end

    initial begin : driver
        for (int k = 0; k < 4; k++) sh_m[k] = 8'hFF;
        reset    = 1'b1;
        in0      = 8'hAC;
        in1      = 8'hFF;
        in2      = 8'hFF;
        in3      = 8'hFF;
        digit_en = 4'hF;
`ifdef DISP_MUX_DIM_EN
        brightness = 4'hF;
`endif
        run(3);
        reset = 1'b0;

        // Frame 0 shows reset shadows (all blank); frame 1 shows AC on digit 0.
        run(64);
        // Mid slot 1 of frame 1: in2 change must wait for the next frame.
        run(24);
        in2 = 8'h9C;
        run(40);
        run(64);

        // Digit 2 disabled for a whole frame, then live enable changes mid-slot.
        digit_en = 4'b1011;
        run(64);
        digit_en = 4'hF;
        run(8);
        digit_en = 4'b0101;
        run(20);
        digit_en = 4'hF;

        // Reset at phase 7 of slot 2, then re-establish the 64-clk tick spacing.
        while (s_m != 39) cyc();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        in0 = 8'h12;
        in3 = 8'h5A;
        run(64 * 2 + 5);

`ifdef DISP_MUX_DIM_EN
        // brightness=3 applies from the next frame latch; a mid-frame change waits too.
        brightness = 4'd3;
        while (s_m != 0) cyc();
        run(64);
        run(20);
        brightness = 4'd15;
        run(44);
        run(64);
`endif

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
